fpu_normalize_round: RTL and testbench

Post-addition normalizer and rounder for the single-precision FMA datapath. It takes the unnormalized sum magnitude produced after addend alignment and the significand add. It performs leading-one detection and a left or right normalization shift, handles subnormal denormalization, rounds, and packs an IEEE-754 binary32 result with exception flags. It is a 2-stage elastic pipeline with a valid/ready handshake, sitting between the significand adder and the FPU writeback.

---
 rtl/fpu_normalize_round.sv | 197 +++++++++++++++++++
 tb/tb_fpu_normalize_round.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_normalize_round.sv
// Binary32 post-add normalizer/rounder: leading-one normalize, subnormal denormalize, round, pack.
// Define FPU_NORM_RM_EN for all five RISC-V rounding modes; otherwise RNE is hard-wired.
module fpu_normalize_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [48:0] in_sig,
    input  logic [9:0]  in_exp,
    input  logic        in_sticky,
    input  logic        in_sign,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags
);
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic s1_valid;
    logic s2_valid;
    logic s1_advance;

    assign s1_advance = ~s2_valid | out_ready;
    assign in_ready   = ~s1_valid | s1_advance;
    assign out_valid  = s2_valid;

    // ---------------- stage 1: leading-one detect and normalize ----------------
    logic [48:0] lead_onehot;
    logic [5:0]  lead_pos;
    logic [48:0] norm_sig;
    logic        sig_nz;
    logic [10:0] exp_unb;
    logic        tiny_d;
    logic [10:0] denorm_dist;
    logic [5:0]  denorm_amt;
    logic [50:0] denorm_sig;
    logic [23:0] mant_d;
    logic        guard_d;
    logic        sticky_d;
    logic [9:0]  exp_field_d;
    logic        zero_d;
    logic [2:0]  rm_d;

    genvar gi;
    generate
        for (gi = 0; gi < 49; gi = gi + 1) begin : g_lead
            assign lead_onehot[gi] = in_sig[gi] & ~(|(in_sig >> (gi + 1)));
        end
    endgenerate

    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < 49; i++) begin
            if (lead_onehot[i]) lead_pos = lead_pos | 6'(i);
        end
    end

    assign sig_nz   = |in_sig;
    assign norm_sig = in_sig << (6'd48 - lead_pos);
    assign exp_unb  = {in_exp[9], in_exp} + {5'd0, lead_pos} - 11'd46;
    // An all-zero magnitude with only alignment sticky lies below every subnormal.
    assign tiny_d      = exp_unb[10] | (exp_unb == 11'd0) | ~sig_nz;
    assign denorm_dist = 11'd1 - exp_unb;

    always_comb begin
        denorm_amt = 6'd0;
        if (tiny_d) begin
            if (!sig_nz || (denorm_dist > 11'd26)) denorm_amt = 6'd26;
            else                                   denorm_amt = denorm_dist[5:0];
        end
    end

    // {mantissa, guard} sits at the top; a shift of 26 clears both completely.
    assign denorm_sig  = {norm_sig[48:24], 26'd0} >> denorm_amt;
    assign mant_d      = denorm_sig[50:27];
    assign guard_d     = denorm_sig[26];
    assign sticky_d    = (|denorm_sig[25:0]) | (|norm_sig[23:0]) | in_sticky;
    assign exp_field_d = tiny_d ? 10'd0 : exp_unb[9:0];
    assign zero_d      = ~sig_nz & ~in_sticky;

`ifdef FPU_NORM_RM_EN
    assign rm_d = (in_rm > RM_RMM) ? RM_RNE : in_rm;
`else
    logic unused_rm;
    assign unused_rm = ^in_rm;
    assign rm_d      = RM_RNE;
`endif

    logic [23:0] s1_mant;
    logic        s1_guard;
    logic        s1_sticky;
    logic [9:0]  s1_exp;
    logic        s1_tiny;
    logic        s1_zero;
    logic        s1_sign;
    logic [2:0]  s1_rm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mant   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_exp    <= '0;
            s1_tiny   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_sign   <= 1'b0;
            s1_rm     <= RM_RNE;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant   <= mant_d;
                s1_guard  <= guard_d;
                s1_sticky <= sticky_d;
                s1_exp    <= exp_field_d;
                s1_tiny   <= tiny_d;
                s1_zero   <= zero_d;
                s1_sign   <= in_sign;
                s1_rm     <= rm_d;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic        round_up;
    logic [24:0] rounded;
    logic        exp_bump;
    logic [10:0] exp_final;
    logic        overflow;
    logic        inexact;
    logic [31:0] ovf_result;
    logic [31:0] result_d;
    logic [4:0]  flags_d;

    always_comb begin
        round_up = 1'b0;
        case (s1_rm)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = (s1_guard | s1_sticky) & s1_sign;
            RM_RUP:  round_up = (s1_guard | s1_sticky) & ~s1_sign;
            RM_RMM:  round_up = s1_guard;
            default: round_up = s1_guard & (s1_sticky | s1_mant[0]);
        endcase
    end

    // A subnormal carrying into the hidden bit becomes the smallest normal.
    assign rounded   = {1'b0, s1_mant} + {24'd0, round_up};
    assign exp_bump  = s1_tiny ? rounded[23] : rounded[24];
    assign exp_final = {1'b0, s1_exp} + {10'd0, exp_bump};
    assign overflow  = exp_final >= 11'd255;
    assign inexact   = s1_guard | s1_sticky | overflow;

`ifdef FPU_NORM_RM_EN
    always_comb begin
        ovf_result = {s1_sign, 8'hFF, 23'd0};
        case (s1_rm)
            RM_RTZ:  ovf_result = {s1_sign, 31'h7F7FFFFF};
            RM_RDN:  ovf_result = s1_sign ? 32'hFF800000 : 32'h7F7FFFFF;
            RM_RUP:  ovf_result = s1_sign ? 32'hFF7FFFFF : 32'h7F800000;
            default: ovf_result = {s1_sign, 8'hFF, 23'd0};
        endcase
    end
`else
    assign ovf_result = {s1_sign, 8'hFF, 23'd0};
`endif

    always_comb begin
        result_d = {s1_sign, exp_final[7:0], rounded[22:0]};
        flags_d  = {2'b00, overflow, s1_tiny & inexact, inexact};
        if (s1_zero) begin
            result_d = {s1_sign, 31'd0};
            flags_d  = 5'd0;
        end else if (overflow) begin
            result_d = ovf_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= result_d;
                out_flags  <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Bench for fpu_normalize_round: directed spec vectors, backpressure, reset, and randomized beats
// checked against an exact-arithmetic rounding model.
`timescale 1ns/1ps
module tb_fpu_normalize_round;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [48:0] in_sig;
    logic [9:0]  in_exp;
    logic        in_sticky;
    logic        in_sign;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    int vectors = 0;
    int miscompares = 0;
    int n_out = 0;
    logic [36:0] exp_q[$];
    bit          stall_seen = 0;
    logic [36:0] held;

    fpu_normalize_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sig     (in_sig),
        .in_exp     (in_exp),
        .in_sticky  (in_sticky),
        .in_sign    (in_sign),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Exact model: pick the output quantum (2^-149 for subnormals, else 23 bits below the
    // leading one), divide the exact value by it, and round the integer quotient.
    function automatic logic [36:0] ref_model(input logic [48:0] sig, input logic [9:0] iexp,
                                              input logic stk, input logic sgn, input logic [2:0] rm_in);
        int p, e_unb, q, k, biased, rm;
        longint unsigned mag, m, rem, half;
        bit above, tie, inexact, up, tiny, of;
        logic [31:0] res;
        logic [4:0]  flags;
`ifdef FPU_NORM_RM_EN
        rm = (rm_in > 3'd4) ? 0 : int'(rm_in);
`else
        rm = (rm_in == 3'd0) ? 0 : 0;
`endif
        if (sig == '0 && !stk) return {sgn, 31'd0, 5'd0};
        p = 0;
        for (int i = 0; i < 49; i++) if (sig[i]) p = i;
        e_unb = int'($signed(iexp)) - 127 + p - 46;
        tiny  = (e_unb < -126);
        q     = tiny ? -149 : e_unb - 23;
        k     = q - (int'($signed(iexp)) - 173);
        mag   = 64'(sig);
        above = 0; tie = 0; rem = 0; half = 0;
        if (k <= 0) begin
            m = mag << (-k);
        end else if (k > 50) begin
            m = 0; rem = mag;
        end else begin
            m    = mag >> k;
            rem  = mag & ((64'd1 << k) - 64'd1);
            half = 64'd1 << (k - 1);
            above = (rem > half) || (rem == half && stk);
            tie   = (rem == half) && !stk;
        end
        inexact = (rem != 0) || stk;
        case (rm)
            1:       up = 0;
            2:       up = inexact && sgn;
            3:       up = inexact && !sgn;
            4:       up = above || tie;
            default: up = above || (tie && m[0]);
        endcase
        m = m + 64'(up);
        if (m == (64'd1 << 24)) begin m = 64'd1 << 23; q++; end
        biased = (m >= (64'd1 << 23)) ? q + 150 : 0;
        of = (biased >= 255);
        if (of) begin
            case (rm)
                1:       res = {sgn, 31'h7F7FFFFF};
                2:       res = sgn ? 32'hFF800000 : 32'h7F7FFFFF;
                3:       res = sgn ? 32'hFF7FFFFF : 32'h7F800000;
                default: res = {sgn, 8'hFF, 23'd0};
            endcase
        end else begin
            res = {sgn, 8'(biased), m[22:0]};
        end
        flags = {2'b00, of, tiny && (inexact || of), inexact || of};
        return {res, flags};
    endfunction

    // Output monitor: scoreboard compare on every handshake, hold check on every stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_seen = 0;
        end else begin
            if (stall_seen) begin
                check("hold_valid", 37'(out_valid), 37'd1);
                check("hold_data", {out_result, out_flags}, held);
            end
            if (out_valid && out_ready) begin
                $display("out %0d: result=%08h flags=%02h", n_out, out_result, out_flags);
                n_out++;
                check("result_expected", 37'(exp_q.size() != 0), 37'd1);
                if (exp_q.size() != 0) check("result", {out_result, out_flags}, exp_q.pop_front());
            end
            stall_seen = out_valid && !out_ready;
            held = {out_result, out_flags};
        end
    end

    task automatic drive(input logic [48:0] sig, input logic [9:0] e, input logic stk,
                         input logic sgn, input logic [2:0] rm);
        in_valid = 1'b1; in_sig = sig; in_exp = e; in_sticky = stk; in_sign = sgn; in_rm = rm;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic send(input logic [48:0] sig, input logic [9:0] e, input logic stk,
                        input logic sgn, input logic [2:0] rm, input logic [36:0] expv);
        int guard = 0;
        drive(sig, e, stk, sgn, rm);
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            guard++;
        end
        check("accept", 37'(in_ready), 37'd1);
        exp_q.push_back(expv);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain", 37'(exp_q.size()), 37'd0);
    endtask

    task automatic dsend(input logic [48:0] sig, input logic [9:0] e, input logic stk,
                         input logic sgn, input logic [2:0] rm, input logic [36:0] expv);
        out_ready = 1'b1;
        send(sig, e, stk, sgn, rm, expv);
        wait_drain();
    endtask

    task automatic latency_beat(input logic [48:0] sig, input logic [9:0] e, input logic sgn,
                                input logic [36:0] expv);
        int cyc;
        out_ready = 1'b1;
        check("idle_in_ready", 37'(in_ready), 37'd1);
        drive(sig, e, 1'b0, sgn, 3'd0);
        exp_q.push_back(expv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 37'(cyc), 37'd2);
        wait_drain();
    endtask

    task automatic rand_beat(output logic [48:0] sig, output logic [9:0] e, output logic stk,
                             output logic sgn, output logic [2:0] rm);
        logic [63:0] r;
        r   = {$urandom(), $urandom()};
        sig = r[48:0] >> $urandom_range(0, 48);
        case ($urandom_range(0, 3))
            0:       e = 10'($urandom_range(0, 60) - 30);
            1:       e = 10'($urandom_range(200, 300));
            2:       e = 10'($urandom());
            default: e = 10'($urandom_range(100, 150));
        endcase
        stk = 1'($urandom_range(0, 1));
        sgn = 1'($urandom_range(0, 1));
        rm  = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) sig = '0;
        if (sig == '0) stk = 1'b0;
    endtask

    initial begin
        logic [48:0] bsig[4];
        logic [9:0]  bexp[4];
        logic        bstk[4];
        logic        bsgn[4];
        logic [2:0]  brm[4];
        logic [48:0] rsig;
        logic [9:0]  rexp;
        logic        rstk, rsgn;
        logic [2:0]  rrm;
        bit          ready_now;
        int          accepted;

        rst_n = 1'b0; in_valid = 1'b0; in_sig = '0; in_exp = '0; in_sticky = 1'b0;
        in_sign = 1'b0; in_rm = 3'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 37'(out_valid), 37'd0);
        check("rst_out_result", 37'(out_result), 37'd0);
        check("rst_out_flags", 37'(out_flags), 37'd0);
        check("rst_in_ready", 37'(in_ready), 37'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        latency_beat(49'd1 << 46, 10'd127, 1'b0, {32'h3F800000, 5'h00});
        dsend(49'd3 << 47, 10'd127, 1'b0, 1'b0, 3'd0, {32'h40C00000, 5'h00});
        dsend(49'd1 << 20, 10'd127, 1'b0, 1'b0, 3'd0, {32'h32800000, 5'h00});
        dsend((49'd1 << 46) | (49'd1 << 22), 10'd127, 1'b0, 1'b0, 3'd0, {32'h3F800000, 5'h01});
        dsend((49'd1 << 46) | (49'd1 << 23) | (49'd1 << 22), 10'd127, 1'b0, 1'b0, 3'd0,
              {32'h3F800002, 5'h01});
`ifdef FPU_NORM_RM_EN
        dsend((49'd1 << 46) | (49'd1 << 23) | (49'd1 << 22), 10'd127, 1'b0, 1'b0, 3'd1,
              {32'h3F800001, 5'h01});
`endif
        dsend(49'd1 << 46, 10'd255, 1'b0, 1'b0, 3'd0, {32'h7F800000, 5'h05});
        dsend(49'd1 << 46, 10'h3E2, 1'b0, 1'b0, 3'd0, {32'h00000000, 5'h03});
        dsend(49'd1 << 45, 10'd1, 1'b0, 1'b0, 3'd0, {32'h00400000, 5'h00});
        dsend(49'd0, 10'd77, 1'b0, 1'b1, 3'd0, {32'h80000000, 5'h00});

        // Backpressure: four beats offered while the consumer stalls.
        for (int i = 0; i < 4; i++) rand_beat(bsig[i], bexp[i], bstk[i], bsgn[i], brm[i]);
        out_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 4; c++) begin
            drive(bsig[accepted], bexp[accepted], bstk[accepted], bsgn[accepted], brm[accepted]);
            @(negedge clk);
            ready_now = in_ready;
            if (ready_now)
                exp_q.push_back(ref_model(bsig[accepted], bexp[accepted], bstk[accepted],
                                          bsgn[accepted], brm[accepted]));
            @(posedge clk); #1;
            if (ready_now) accepted++;
        end
        check("bp_accepted", 37'(accepted), 37'd2);
        check("bp_in_ready", 37'(in_ready), 37'd0);
        out_ready = 1'b1;
        for (int i = 2; i < 4; i++)
            send(bsig[i], bexp[i], bstk[i], bsgn[i], brm[i],
                 ref_model(bsig[i], bexp[i], bstk[i], bsgn[i], brm[i]));
        wait_drain();
        check("bp_out_count", 37'(n_out), 37'd13 - 37'(1 - $bits(in_rm) / 3)
`ifdef FPU_NORM_RM_EN
              + 37'd1
`endif
        );

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(49'd1 << 46, 10'd130, 1'b0, 1'b0, 3'd0, 37'd0);
        send(49'd1 << 46, 10'd131, 1'b0, 1'b0, 3'd0, 37'd0);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 37'(out_valid), 37'd0);
        check("midrst_out_result", 37'(out_result), 37'd0);
        check("midrst_out_flags", 37'(out_flags), 37'd0);
        check("midrst_in_ready", 37'(in_ready), 37'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no_stale", 37'(out_valid), 37'd0);
        end
        latency_beat(49'd1 << 46, 10'd127, 1'b1, {32'hBF800000, 5'h00});

        // Randomized beats with random consumer stalls and input bubbles.
        for (int n = 0; n < 300; n++) begin
            rand_beat(rsig, rexp, rstk, rsgn, rrm);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
            send(rsig, rexp, rstk, rsgn, rrm, ref_model(rsig, rexp, rstk, rsgn, rrm));
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
